// File: rtl/ram_arbiter_2p_if.sv
// Requester-side bundle for ram_arbiter_2p: two req/ack transaction ports
// with per-port read data return.
interface ram_arbiter_2p_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1
    );
endinterface

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter/sequencer serialising two requesters onto one
// single-port RAM with a registered read (write when ram_sel=1).
module ram_arbiter_2p #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_arbiter_2p_if.slave       bus,
    output logic                  ram_sel,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_r;
    logic                  last_grant_r;
    logic                  gnt_r;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  ack0_r;
    logic                  ack1_r;
    logic [DATA_WIDTH-1:0] rdata0_r;
    logic [DATA_WIDTH-1:0] rdata1_r;

    logic                  elig0_s;
    logic                  elig1_s;
    logic                  any_s;
    logic                  pick_s;
    logic                  nxt_we_s;
    logic [ADDR_WIDTH-1:0] nxt_addr_s;
    logic [DATA_WIDTH-1:0] nxt_wdata_s;

    // Eligibility, round-robin pick and the fields of the picked port.
    always_comb begin
        elig0_s = bus.req0 & ~ack0_r;
        elig1_s = bus.req1 & ~ack1_r;
        any_s   = elig0_s | elig1_s;
        if (elig0_s && elig1_s) begin
            pick_s = ~last_grant_r;
        end else begin
            pick_s = elig1_s;
        end
        if (pick_s) begin
            nxt_we_s    = bus.we1;
            nxt_addr_s  = bus.addr1;
            nxt_wdata_s = bus.wdata1;
        end else begin
            nxt_we_s    = bus.we0;
            nxt_addr_s  = bus.addr0;
            nxt_wdata_s = bus.wdata0;
        end
    end

    // Sequencer FSM with latched transaction fields and registered ack/rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            gnt_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            rdata0_r     <= '0;
            rdata1_r     <= '0;
        end else begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        gnt_r        <= pick_s;
                        last_grant_r <= pick_s;
                        we_r         <= nxt_we_s;
                        addr_r       <= nxt_addr_s;
                        wdata_r      <= nxt_wdata_s;
                        state_r      <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_r <= DONE;
                end
                DONE: begin
                    // ram_dout now holds the registered read from ACCESS.
                    if (gnt_r) begin
                        ack1_r <= 1'b1;
                        if (!we_r) begin
                            rdata1_r <= ram_dout;
                        end
                    end else begin
                        ack0_r <= 1'b1;
                        if (!we_r) begin
                            rdata0_r <= ram_dout;
                        end
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // The RAM writes on every edge with sel high, so qualify by state.
    assign ram_sel    = (state_r == ACCESS) && we_r;
    assign ram_addr   = addr_r;
    assign ram_din    = wdata_r;
    assign bus.ack0   = ack0_r;
    assign bus.ack1   = ack1_r;
    assign bus.rdata0 = rdata0_r;
    assign bus.rdata1 = rdata1_r;
endmodule

// File: doc/ram_arbiter_2p.md
# ram_arbiter_2p

Two-port round-robin arbiter and sequencer for the single-port 4-word × 4-bit R/W RAM (write when `sel`=1, registered read otherwise). Two requesters issue read/write transactions through a req/ack handshake. The block serialises them onto the one RAM port, drives `sel`/`addr`/`din`, captures the registered `dout`, and returns read data per port. It sits between the requesters and the RAM instance; the RAM itself is external.

## Interface
- `ADDR_WIDTH`, default 2: RAM address width.
- `DATA_WIDTH`, default 4: RAM data width.

- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `req0`, `req1`  in  1  transaction request; held high until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req high.
- `addr0`, `addr1`  in  ADDR_WIDTH  target address; stable while req high.
- `wdata0`, `wdata1`  in  DATA_WIDTH  write data; stable while req high.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DATA_WIDTH  last read result for that port; held until the port's next read completes.
- `ram_sel`  out  1  to RAM `sel`.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_din`  out  DATA_WIDTH  to RAM `din`.
- `ram_dout`  in  DATA_WIDTH  from RAM `dout`.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: port N is eligible when `reqN`=1 and `ackN`=0.
  - Neither port eligible: stay in IDLE.
  - One port eligible: grant it.
  - Both eligible: grant the port other than `last_grant`.
  - On grant: latch `we`, `addr`, `wdata` and the granted port id, set `last_grant` to that id, go to ACCESS.
- ACCESS: `ram_addr` = latched addr, `ram_din` = latched wdata, `ram_sel` = latched we. The RAM writes or reads at the closing edge. Always go to DONE.
- DONE: `ram_sel`=0. At the closing edge:
  - `ack` of the granted port is set to 1 (registered).
  - For a read, `rdata` of the granted port is loaded from `ram_dout`.
  - Go to IDLE.
- `ackN` is a registered single-cycle pulse and clears on the following edge.
- `ram_sel` is combinational: high only in ACCESS with a latched write. It is never high in any other state, because the RAM writes on every edge where `sel`=1.
- Outside ACCESS, `ram_addr`/`ram_din` keep the last latched values. The RAM performs harmless reads.
- The acked port is ineligible during its ack cycle. A requester may change fields on the ack edge; a continuously held req is re-served with whatever fields it presents.
- Reset values:
  - State IDLE, `last_grant`=1, so port 0 wins the first contention.
  - `ack0`=`ack1`=0, `rdata0`=`rdata1`=0.
  - Latched addr/data/we = 0, so `ram_sel`=0, `ram_addr`=0, `ram_din`=0.
- Reset mid-operation: the FSM returns to IDLE and no ack is issued.
  - If `rst` is sampled at the ACCESS closing edge of a write, the RAM still commits the write, since the RAM has no reset.
  - A reset in DONE drops the ack and the rdata update.

## Timing
- E0 = edge where IDLE samples an eligible req. ACCESS runs from E0 to E1, DONE from E1 to E2.
- `ackN` and read `rdataN` are valid in the cycle after E2. Latency from request sampled to ack visible is 3 cycles.
- Next grant is possible at E3: the other port if it is requesting, otherwise the same port once its ack has cleared (E4 earliest for the same port).
- Sustained throughput with both ports busy: one transaction every 3 cycles, alternating 0,1,0,1.
- Write data is in the RAM after E1. A read grant issued at or after E2 observes it.

## Test plan
- Reset, then port 0 write addr 2 data 0xA. Expect `ram_sel`=1 for exactly one cycle with `ram_addr`=2 and `ram_din`=0xA, and `ack0` 3 cycles after the req is sampled.
- Then port 0 read addr 2. Expect `ram_sel` to stay 0 throughout, `ack0` pulse, `rdata0`=0xA, and `rdata1` unchanged at 0.
- `req0` and `req1` both raised in the same cycle after reset (both writes, addr 0/1, data 0x3/0xC). Expect port 0 acked first and port 1 acked 3 cycles later. Reading back addr 0 and 1 gives 0x3 and 0xC.
- Both reqs held high for 8 transactions. Expect strict ack alternation 0,1,0,1,… with ack spacing of 3 cycles and never two acks in the same cycle.
- Port 1 writes addr 3 data 0x5; port 0 then reads addr 3. Expect `rdata0`=0x5.
- `rst` pulsed during DONE of a read on port 1. Expect no `ack1`, `rdata1`=0, all outputs at reset values the next cycle, and the following transaction to complete normally.
